// File: rtl/hw_imp_pkg.sv
// hw_imp_pkg: shared constants, state enum and register bit positions for hw_imp_core
package hw_imp_pkg;
  localparam logic [31:0] DELTA = 32'h9E3779B9;
  localparam int NUM_CYCLES = 32;
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
  localparam int ST_DONE = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_MODE = 2;
  localparam int CTL_CLEAR = 0;
  localparam int CTL_MODE = 1;
  function automatic logic [31:0] mix(input logic [31:0] v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction
endpackage

// File: rtl/hw_imp_core_xtea_round.sv
// xtea_round: one combinational XTEA cycle (two Feistel half-rounds) on a 64-bit block
// ports: v0/v1 block halves, sum running schedule value, key 4x32 key words,
//        mode 0 encrypt / 1 decrypt, v0_n/v1_n/sum_n updated values
module xtea_round
  import hw_imp_pkg::*;
(
  input  logic [31:0]       v0,
  input  logic [31:0]       v1,
  input  logic [31:0]       sum,
  input  logic [3:0][31:0]  key,
  input  logic              mode,
  output logic [31:0]       v0_n,
  output logic [31:0]       v1_n,
  output logic [31:0]       sum_n
);
  logic [31:0] e_v0, e_v1, e_sum, d_v0, d_v1, d_sum;
  always_comb begin
    e_v0 = v0 + (mix(v1) ^ (sum + key[sum[1:0]]));
    e_sum = sum + DELTA;
    e_v1 = v1 + (mix(e_v0) ^ (e_sum + key[e_sum[12:11]]));
    d_v1 = v1 - (mix(v0) ^ (sum + key[sum[12:11]]));
    d_sum = sum - DELTA;
    d_v0 = v0 - (mix(d_v1) ^ (d_sum + key[d_sum[1:0]]));
    v0_n = mode ? d_v0 : e_v0;
    v1_n = mode ? d_v1 : e_v1;
    sum_n = mode ? d_sum : e_sum;
  end
endmodule

// File: rtl/hw_imp_core.sv
// hw_imp_core: Avalon-MM XTEA accelerator encrypting two 64-bit ECB blocks in parallel
// ports: clk, reset (synchronous, active-low), address (0 control/status, 1 data port),
//        write/writedata, read/readdata (combinational, 0 unless a read is accepted),
//        waitrequest (stalls data-port transfers while the engine runs)
// build option: HW_IMP_DECRYPT_EN makes control bit1 select decryption
module hw_imp_core
  import hw_imp_pkg::*;
#(
  parameter int NUM_CYCLES = hw_imp_pkg::NUM_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest
);
  localparam int RW = $clog2(NUM_CYCLES + 1);
  state_t state, state_n;
  logic [2:0] wcnt;
  logic [1:0] rcnt;
  logic [RW-1:0] rnd;
  logic [3:0][31:0] txt, key;
  logic [31:0] sum, a0, a1, b0, b1, sum_a, unused_sum_b, status;
  logic done, mode, last, crd, cwr, clr, drd, dwr;
  always_comb begin
    crd = read && !address;
    cwr = write && !address;
    clr = cwr && writedata[CTL_CLEAR];
    drd = read && address && state == DONE;
    // a data write alongside a data read is dropped so the read wins
    dwr = write && address && !read && state == LOAD;
    last = rnd == RW'(NUM_CYCLES - 1);
    waitrequest = state == RUN && address && (read || write);
    status = '0;
    status[ST_DONE] = done;
    status[ST_BUSY] = state == RUN;
    status[ST_MODE] = mode;
    readdata = crd ? status : drd ? txt[rcnt] : '0;
    state_n = clr ? LOAD
            : dwr && wcnt == 3'd7 ? RUN
            : state == RUN && last ? DONE
            : drd && rcnt == 2'd3 ? LOAD
            : state;
  end
  xtea_round u_a (
    .v0(txt[0]), .v1(txt[1]), .sum(sum), .key(key), .mode(mode),
    .v0_n(a0), .v1_n(a1), .sum_n(sum_a)
  );
  xtea_round u_b (
    .v0(txt[2]), .v1(txt[3]), .sum(sum), .key(key), .mode(mode),
    .v0_n(b0), .v1_n(b1), .sum_n(unused_sum_b)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= LOAD;
      wcnt <= '0;
      rcnt <= '0;
      rnd <= '0;
      txt <= '0;
      key <= '0;
      sum <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      if (clr) begin
        wcnt <= '0;
        rcnt <= '0;
        rnd <= '0;
        done <= 1'b0;
      end else begin
        if (dwr) begin
          wcnt <= wcnt + 3'd1;
          if (wcnt[2]) key[wcnt[1:0]] <= writedata;
          else txt[wcnt[1:0]] <= writedata;
          if (wcnt == 3'd7) begin
            rnd <= '0;
            sum <= mode ? DELTA * NUM_CYCLES : '0;
          end
        end
        if (state == RUN) begin
          txt <= {b1, b0, a1, a0};
          sum <= sum_a;
          rnd <= rnd + 1'b1;
          if (last) done <= 1'b1;
        end
        if (drd) begin
          rcnt <= rcnt + 2'd1;
          if (rcnt == 2'd3) done <= 1'b0;
        end
      end
    end
  end
`ifdef HW_IMP_DECRYPT_EN
  always_ff @(posedge clk) begin
    if (!reset) mode <= 1'b0;
    else if (cwr) mode <= writedata[CTL_MODE];
  end
`else
  assign mode = 1'b0;
`endif
endmodule

// File: tb/tb_hw_imp_core.sv
// tb_hw_imp_core: randomized self-checking bench for hw_imp_core against a C-style XTEA model
module tb_hw_imp_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  int n_tests = 0;
  int n_fail = 0;

  hw_imp_core dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] xtea_ref(input logic [31:0] v0, input logic [31:0] v1,
                                           input logic [3:0][31:0] k, input bit dec);
    logic [31:0] s;
    s = dec ? 32'h9E3779B9 * 32 : 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (!dec) begin
        v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + k[s % 4]);
        s += 32'h9E3779B9;
        v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + k[(s >> 11) % 4]);
      end else begin
        v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + k[(s >> 11) % 4]);
        s -= 32'h9E3779B9;
        v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + k[s % 4]);
      end
    end
    return {v0, v1};
  endfunction

  task automatic do_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1; read = 1'b0;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic do_read(input logic a, output logic [31:0] d, output logic w);
    @(negedge clk);
    address = a; read = 1'b1; write = 1'b0;
    #1;
    d = readdata;
    w = waitrequest;
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  task automatic load(input logic [3:0][31:0] pt, input logic [3:0][31:0] k);
    for (int i = 0; i < 4; i++) do_write(1'b1, pt[i]);
    for (int i = 0; i < 4; i++) do_write(1'b1, k[i]);
  endtask

  task automatic read_results(input bit wr_too, output logic [3:0][31:0] ct, output int stalls);
    stalls = 0;
    @(negedge clk);
    address = 1'b1; read = 1'b1; write = wr_too; writedata = $urandom;
    for (int j = 0; j < 4; j++) begin
      #1;
      while (waitrequest && stalls < 200) begin
        stalls++;
        @(negedge clk);
        #1;
      end
      ct[j] = readdata;
      @(posedge clk);
      #1;
      if (j < 3) @(negedge clk);
    end
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic check_words(input string tag, input logic [3:0][31:0] pt,
                             input logic [3:0][31:0] k, input bit dec,
                             input logic [3:0][31:0] ct);
    logic [63:0] ea, eb;
    ea = xtea_ref(pt[0], pt[1], k, dec);
    eb = xtea_ref(pt[2], pt[3], k, dec);
    check({tag, "_w0"}, ct[0], ea[63:32]);
    check({tag, "_w1"}, ct[1], ea[31:0]);
    check({tag, "_w2"}, ct[2], eb[63:32]);
    check({tag, "_w3"}, ct[3], eb[31:0]);
  endtask

  task automatic run_check(input string tag, input logic [3:0][31:0] pt,
                           input logic [3:0][31:0] k, input bit wr_too, input bit dec,
                           output logic [3:0][31:0] ct);
    int stalls;
    load(pt, k);
    read_results(wr_too, ct, stalls);
    check({tag, "_stalls"}, stalls, 32);
    check_words(tag, pt, k, dec, ct);
  endtask

  logic [3:0][31:0] pt, k, ct, vct;
  logic [31:0] d;
  logic w;
  int stalls;

  initial begin
    reset = 1'b0; address = 1'b0; write = 1'b0; read = 1'b0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_waitreq", {31'd0, waitrequest}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_read(1'b0, d, w);
    check("idle_status", d, 32'd0);
    check("idle_status_wait", {31'd0, w}, 32'd0);
    do_read(1'b1, d, w);
    check("load_data_read", d, 32'd0);
    check("load_data_wait", {31'd0, w}, 32'd0);
    pt = {32'h98765432, 32'h10fedcba, 32'h77665544, 32'h33221100};
    k = {32'h12345678, 32'h9abcdef0, 32'haabbccdd, 32'heeff0011};
    run_check("vec", pt, k, 1'b0, 1'b0, vct);
    do_read(1'b0, d, w);
    check("after_read_status", d, 32'd0);
    run_check("zero", '0, '0, 1'b0, 1'b0, ct);
    check("zero_ab_v0", ct[0], ct[2]);
    check("zero_ab_v1", ct[1], ct[3]);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pt[j] = $urandom;
        k[j] = $urandom;
      end
      run_check($sformatf("rnd%0d", i), pt, k, i[0], 1'b0, ct);
    end
    for (int j = 0; j < 4; j++) begin
      pt[j] = $urandom;
      k[j] = $urandom;
    end
    load(pt, k);
    do_read(1'b0, d, w);
    check("run_status", d, 32'd2);
    repeat (7) @(posedge clk);
    do_write(1'b0, 32'd1);
    do_read(1'b0, d, w);
    check("abort_status", d, 32'd0);
    for (int j = 0; j < 4; j++) begin
      pt[j] = $urandom;
      k[j] = $urandom;
    end
    run_check("post_abort", pt, k, 1'b0, 1'b0, ct);
    load(pt, k);
    repeat (40) @(posedge clk);
    do_read(1'b0, d, w);
    check("done_status", d, 32'd1);
    do_write(1'b1, $urandom);
    do_write(1'b1, $urandom);
    read_results(1'b0, ct, stalls);
    check("done_stalls", stalls, 32'd0);
    check_words("done_wr_ignored", pt, k, 1'b0, ct);
    do_write(1'b0, 32'd2);
    do_read(1'b0, d, w);
`ifdef HW_IMP_DECRYPT_EN
    check("mode_status", d, 32'd4);
    pt = {32'h98765432, 32'h10fedcba, 32'h77665544, 32'h33221100};
    k = {32'h12345678, 32'h9abcdef0, 32'haabbccdd, 32'heeff0011};
    load(vct, k);
    read_results(1'b0, ct, stalls);
    check("dec_stalls", stalls, 32'd32);
    for (int j = 0; j < 4; j++) check($sformatf("dec_w%0d", j), ct[j], pt[j]);
    do_write(1'b0, 32'd0);
`else
    check("mode_status", d, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
